aes_round_engine: RTL and testbench



---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_round_engine_if.sv | 28 ++
 rtl/aes_key_step.sv | 20 ++
 rtl/sbox.sv | 20 ++
 rtl/sub_byte.sv | 10 +
 rtl/aes_round_engine.sv | 93 +++++++++
 tb/tb_aes_round_engine.sv | 154 +++++++++++++++
 7 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, constants and GF(2^8) helpers
// Contents: state_t FSM encoding, NR/BLOCK_W, RCON[1:10], xtime, gf_mul
package aes_pkg;
    localparam int NR = 10;
    localparam int BLOCK_W = 128;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction
endpackage

// File: rtl/aes_round_engine_if.sv
// aes_round_engine_if: block-in / ciphertext-out handshake bundle
// Signals: in_valid/in_ready/plaintext/key (input side),
// out_valid/out_ready/ciphertext (output side), last_key with AES_LAST_KEY_OUT_EN
interface aes_round_engine_if;
    import aes_pkg::*;
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] plaintext;
    logic [BLOCK_W-1:0] key;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] ciphertext;
`ifdef AES_LAST_KEY_OUT_EN
    logic [BLOCK_W-1:0] last_key;
`endif
    modport master (output in_valid, plaintext, key, out_ready,
                    input in_ready, out_valid, ciphertext
`ifdef AES_LAST_KEY_OUT_EN
                    , last_key
`endif
                    );
    modport slave (input in_valid, plaintext, key, out_ready,
                   output in_ready, out_valid, ciphertext
`ifdef AES_LAST_KEY_OUT_EN
                   , last_key
`endif
                   );
endinterface

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-schedule step, combinational
// Ports: key_in (previous round key), rcon (round constant), key_out (next round key)
module aes_key_step (
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    output logic [127:0] key_out
);
    logic [31:0] rot;
    logic [31:0] sub;
    logic [31:0] w4, w5, w6, w7;
    assign rot = {key_in[23:0], key_in[31:24]};
    for (genvar i = 0; i < 4; i++) begin : g_sw
        sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
    end
    assign w4 = key_in[127:96] ^ sub ^ {rcon, 24'h0};
    assign w5 = key_in[95:64] ^ w4;
    assign w6 = key_in[63:32] ^ w5;
    assign w7 = key_in[31:0] ^ w6;
    assign key_out = {w4, w5, w6, w7};
endmodule

// File: rtl/sbox.sv
// sbox: AES forward S-box, multiplicative inverse followed by the affine map
// Ports: a (byte in), y (substituted byte)
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] inv;
    // a^254 is the GF(2^8) inverse and maps 0 to 0 as AES requires
    always_comb begin
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (i != 0) inv = gf_mul(inv, a);
        end
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// File: rtl/sub_byte.sv
// sub_byte: SubBytes over the full 128-bit state
// Ports: din (state), dout (substituted state)
module sub_byte (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar i = 0; i < 16; i++) begin : g_sb
        sbox u_sbox (.a(din[8*i +: 8]), .y(dout[8*i +: 8]));
    end
endmodule

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES-128 encryptor, one round per clock
// Ports: clk, rst (sync, active-high), bus (aes_round_engine_if.slave).
// Define AES_LAST_KEY_OUT_EN to expose the round-10 key on bus.last_key.
module aes_round_engine
    import aes_pkg::*;
(
    input  logic clk,
    input  logic rst,
    aes_round_engine_if.slave bus
);
    state_t       fsm;
    logic [3:0]   round;
    logic [127:0] state, key_reg, next_key, sb, sr, rnd_out;
    logic [7:0]   rcon;
    // state byte b = 4*col + row lives at bits [127-8b -: 8]
    function automatic logic [7:0] byte_at(input logic [127:0] s, input int c, input int r);
        return s[127 - 8*(4*c + r) -: 8];
    endfunction
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = byte_at(s, (c + r) % 4, r);
        return o;
    endfunction
    // circulant {02,03,01,01}: 3*x is folded into xtime(x)^x
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = xtime(byte_at(s, c, r))
                    ^ xtime(byte_at(s, c, (r + 1) % 4)) ^ byte_at(s, c, (r + 1) % 4)
                    ^ byte_at(s, c, (r + 2) % 4) ^ byte_at(s, c, (r + 3) % 4);
        return o;
    endfunction
    assign rcon = (round >= 4'd1 && round <= 4'(NR)) ? RCON[round] : 8'h00;
    sub_byte u_sub_byte (.din(state), .dout(sb));
    aes_key_step u_key_step (.key_in(key_reg), .rcon(rcon), .key_out(next_key));
    assign sr = shift_rows(sb);
    assign rnd_out = (round == 4'(NR) ? sr : mix_columns(sr)) ^ next_key;
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm            <= IDLE;
            round          <= 4'd0;
            state          <= '0;
            key_reg        <= '0;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.ciphertext <= '0;
`ifdef AES_LAST_KEY_OUT_EN
            bus.last_key   <= '0;
`endif
        end else begin
            case (fsm)
                IDLE: if (bus.in_valid) begin
                    state        <= bus.plaintext ^ bus.key;
                    key_reg      <= bus.key;
                    round        <= 4'd1;
                    fsm          <= RUN;
                    bus.in_ready <= 1'b0;
                end
                RUN: if (round < 4'd1 || round > 4'(NR)) begin
                    fsm          <= IDLE;
                    bus.in_ready <= 1'b1;
                end else begin
                    state   <= rnd_out;
                    key_reg <= next_key;
                    round   <= round + 4'd1;
                    if (round == 4'(NR)) begin
                        bus.ciphertext <= rnd_out;
`ifdef AES_LAST_KEY_OUT_EN
                        bus.last_key   <= next_key;
`endif
                        bus.out_valid  <= 1'b1;
                        fsm            <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    fsm           <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                end
                default: begin
                    fsm           <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: directed FIPS-197 vectors, latency, backpressure, reset, streaming
module tb_aes_round_engine;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_LK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    aes_round_engine_if bus();
    aes_round_engine dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [127:0] pt, input logic [127:0] k);
        for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
        chk("send_ready", 128'(bus.in_ready), 128'd1);
        bus.plaintext = pt;
        bus.key = k;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask
    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
    endtask
    task automatic drain;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("drain_out_valid", 128'(bus.out_valid), 128'd0);
        chk("drain_in_ready", 128'(bus.in_ready), 128'd1);
    endtask
    initial begin
        int lat;
        int cyc;
        int nacc;
        int nout;
        int acc [2];
        logic [127:0] got [2];
        logic r;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.plaintext = '0;
        bus.key = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_ciphertext", bus.ciphertext, 128'd0);
`ifdef AES_LAST_KEY_OUT_EN
        chk("rst_last_key", bus.last_key, 128'd0);
`endif
        // FIPS-197 C.1 with latency
        send(C1_PT, C1_KEY);
        chk("c1_busy", 128'(bus.in_ready), 128'd0);
        wait_out(lat);
        chk("c1_latency", 128'(lat), 128'd10);
        chk("c1_ct", bus.ciphertext, C1_CT);
        drain();
        // App.B with inputs scrambled after acceptance
        send(B_PT, B_KEY);
        bus.plaintext = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        bus.key = 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a;
        wait_out(lat);
        chk("b_latency", 128'(lat), 128'd10);
        chk("b_ct", bus.ciphertext, B_CT);
`ifdef AES_LAST_KEY_OUT_EN
        chk("b_last_key", bus.last_key, B_LK);
`endif
        // backpressure, with a second request presented while DONE
        bus.plaintext = C1_PT;
        bus.key = C1_KEY;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_ct_stable", bus.ciphertext, B_CT);
            chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
            chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
        end
        bus.in_valid = 1'b0;
        drain();
        repeat (3) tick();
        chk("bp_no_second_out", 128'(bus.out_valid), 128'd0);
        chk("bp_idle_ready", 128'(bus.in_ready), 128'd1);
        // reset at round 5
        send(B_PT, B_KEY);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("mid_rst_ct", bus.ciphertext, 128'd0);
        send(C1_PT, C1_KEY);
        wait_out(lat);
        chk("post_rst_latency", 128'(lat), 128'd10);
        chk("post_rst_ct", bus.ciphertext, C1_CT);
        drain();
        // back-to-back with out_ready tied high
        acc = '{0, 0};
        got = '{128'd0, 128'd0};
        cyc = 0;
        nacc = 0;
        nout = 0;
        bus.out_ready = 1'b1;
        bus.plaintext = B_PT;
        bus.key = B_KEY;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 60 && nout < 2; k++) begin
            r = bus.in_ready;
            tick();
            cyc++;
            if (r && bus.in_valid && nacc < 2) begin
                acc[nacc] = cyc;
                nacc++;
                if (nacc == 1) begin
                    bus.plaintext = C1_PT;
                    bus.key = C1_KEY;
                end else bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                got[nout] = bus.ciphertext;
                nout++;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b_outputs", 128'(nout), 128'd2);
        chk("b2b_spacing", 128'(acc[1] - acc[0]), 128'd12);
        chk("b2b_ct0", got[0], B_CT);
        chk("b2b_ct1", got[1], C1_CT);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
